// File: rtl/vsd_caravel_if.sv
// Housekeeping SPI pins. The host drives clock, select and data in.
// The device drives data out and its output enable.
interface vsd_caravel_if;
    logic hk_sck;
    logic hk_csb;
    logic hk_sdi;
    logic hk_sdo;
    logic hk_sdo_oe;

    modport master (output hk_sck, hk_csb, hk_sdi, input  hk_sdo, hk_sdo_oe);
    modport slave  (input  hk_sck, hk_csb, hk_sdi, output hk_sdo, hk_sdo_oe);
endinterface

// File: rtl/vsd_caravel.sv
// Housekeeping SPI slave. A command/address/data byte stream accesses a small
// configuration register file that drives the PLL and system control outputs.
module vsd_caravel #(
    parameter logic [11:0] MFG_ID  = 12'h456,
    parameter logic [7:0]  PROD_ID = 8'h11,
    parameter logic [31:0] USER_ID = 32'h0
) (
    input  logic         clock,
    input  logic         resetb,
    vsd_caravel_if.slave hk,
    input  logic         trap,
    output logic         pll_ena,
    output logic         pll_dco_ena,
    output logic         pll_bypass,
    output logic         irq,
    output logic         ext_reset,
    output logic [25:0]  pll_trim,
    output logic [5:0]   pll_sel,
    output logic [4:0]   pll_div
);

    typedef enum logic [1:0] {ST_COMMAND, ST_ADDRESS, ST_DATA, ST_IGNORE} state_t;
    state_t state_q, state_d;

    logic [2:0] sck_sync;
    logic [1:0] csb_sync;
    logic [1:0] sdi_sync;
    logic       armed;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] shift_out;
    logic [7:0] addr_q;
    logic       cmd_rd, cmd_wr, sdo_q;

    logic [1:0] r08;
    logic       r09, r0a, r0b;
    logic [7:0] r0d, r0e, r0f;
    logic [1:0] r10;
    logic [5:0] r11;
    logic [4:0] r12;

    logic       active, sck_rise, sck_fall, byte_done, cmd_ok;
    logic [7:0] byte_in, rd_addr, rd_data;

    // armed stays low after reset until chip select is seen high, so a transfer
    // already in flight when reset was released is ignored in full.
    assign active    = armed & ~csb_sync[1];
    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign byte_in   = {shift_in, sdi_sync[1]};
    assign byte_done = active & sck_rise & (bit_cnt == 3'd7);
    assign cmd_ok    = (byte_in == 8'h80) || (byte_in == 8'h40) || (byte_in == 8'hC0);

    always_ff @(posedge clock) begin
        if (!resetb) begin
            sck_sync <= '0;
            csb_sync <= '0;
            sdi_sync <= '0;
            armed    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[1:0], hk.hk_sck};
            csb_sync <= {csb_sync[0], hk.hk_csb};
            sdi_sync <= {sdi_sync[0], hk.hk_sdi};
            if (csb_sync[1]) armed <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) state_q <= ST_COMMAND;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!active) begin
            state_d = ST_COMMAND;
        end else if (byte_done) begin
            case (state_q)
                ST_COMMAND: state_d = cmd_ok ? ST_ADDRESS : ST_IGNORE;
                ST_ADDRESS: state_d = ST_DATA;
                default:    state_d = state_q;
            endcase
        end
    end

    // The readback path serves the address byte itself, or the next address while streaming.
    assign rd_addr = (state_q == ST_ADDRESS) ? byte_in : addr_q + 8'd1;

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            8'h01: rd_data = {4'h0, MFG_ID[11:8]};
            8'h02: rd_data = MFG_ID[7:0];
            8'h03: rd_data = PROD_ID;
            8'h04: rd_data = USER_ID[31:24];
            8'h05: rd_data = USER_ID[23:16];
            8'h06: rd_data = USER_ID[15:8];
            8'h07: rd_data = USER_ID[7:0];
            8'h08: rd_data = {6'h0, r08};
            8'h09: rd_data = {7'h0, r09};
            8'h0a: rd_data = {7'h0, r0a};
            8'h0b: rd_data = {7'h0, r0b};
            8'h0c: rd_data = {7'h0, trap};
            8'h0d: rd_data = r0d;
            8'h0e: rd_data = r0e;
            8'h0f: rd_data = r0f;
            8'h10: rd_data = {6'h0, r10};
            8'h11: rd_data = {2'h0, r11};
            8'h12: rd_data = {3'h0, r12};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            addr_q    <= '0;
            cmd_rd    <= 1'b0;
            cmd_wr    <= 1'b0;
            sdo_q     <= 1'b0;
            r08 <= 2'h2;
            r09 <= 1'b1;
            r0a <= 1'b0;
            r0b <= 1'b0;
            r0d <= 8'hff;
            r0e <= 8'hef;
            r0f <= 8'hff;
            r10 <= 2'h3;
            r11 <= 6'h12;
            r12 <= 5'h04;
        end else if (!active) begin
            bit_cnt <= '0;
            sdo_q   <= 1'b0;
        end else if (sck_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= byte_in[6:0];
            if (bit_cnt == 3'd7) begin
                case (state_q)
                    ST_COMMAND: begin
                        cmd_rd <= cmd_ok & byte_in[6];
                        cmd_wr <= cmd_ok & byte_in[7];
                    end
                    ST_ADDRESS: begin
                        addr_q    <= byte_in;
                        shift_out <= rd_data;
                    end
                    ST_DATA: begin
                        addr_q    <= addr_q + 8'd1;
                        shift_out <= rd_data;
                        if (cmd_wr) begin
                            case (addr_q)
                                8'h08: r08 <= byte_in[1:0];
                                8'h09: r09 <= byte_in[0];
                                8'h0a: r0a <= byte_in[0];
                                8'h0b: r0b <= byte_in[0];
                                8'h0d: r0d <= byte_in;
                                8'h0e: r0e <= byte_in;
                                8'h0f: r0f <= byte_in;
                                8'h10: r10 <= byte_in[1:0];
                                8'h11: r11 <= byte_in[5:0];
                                8'h12: r12 <= byte_in[4:0];
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end else if (sck_fall && state_q == ST_DATA && cmd_rd) begin
            sdo_q     <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
        end
    end

    assign hk.hk_sdo    = sdo_q;
    assign hk.hk_sdo_oe = active & (state_q == ST_DATA) & cmd_rd;

    assign pll_ena     = r08[0];
    assign pll_dco_ena = r08[1];
    assign pll_bypass  = r09;
    assign irq         = r0a;
    assign ext_reset   = r0b;
    assign pll_trim    = {r10, r0f, r0e, r0d};
    assign pll_sel     = r11;
    assign pll_div     = r12;

endmodule

// File: tb/tb_vsd_caravel.sv
// Bench for vsd_caravel. An SPI host issues directed and random transfers.
// Expected read bytes are queued and matched by an independent sdo monitor.
module tb_vsd_caravel;
    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        resetb;
    logic        trap;
    logic        pll_ena, pll_dco_ena, pll_bypass, irq, ext_reset;
    logic [25:0] pll_trim;
    logic [5:0]  pll_sel;
    logic [4:0]  pll_div;

    vsd_caravel_if hk();

    vsd_caravel #(.MFG_ID(12'h456), .PROD_ID(8'h11), .USER_ID(32'h0)) dut (
        .clock(clock), .resetb(resetb), .hk(hk), .trap(trap),
        .pll_ena(pll_ena), .pll_dco_ena(pll_dco_ena), .pll_bypass(pll_bypass),
        .irq(irq), .ext_reset(ext_reset), .pll_trim(pll_trim),
        .pll_sel(pll_sel), .pll_div(pll_div)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[256];
    logic [7:0] wmask[256];
    logic [7:0] tx_buf[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference register file: reset image and writable-bit mask per address.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            wmask[i] = 8'h00;
        end
        mem[8'h01] = 8'h04; mem[8'h02] = 8'h56; mem[8'h03] = 8'h11;
        mem[8'h08] = 8'h02; wmask[8'h08] = 8'h03;
        mem[8'h09] = 8'h01; wmask[8'h09] = 8'h01;
        wmask[8'h0a] = 8'h01;
        wmask[8'h0b] = 8'h01;
        mem[8'h0d] = 8'hff; wmask[8'h0d] = 8'hff;
        mem[8'h0e] = 8'hef; wmask[8'h0e] = 8'hff;
        mem[8'h0f] = 8'hff; wmask[8'h0f] = 8'hff;
        mem[8'h10] = 8'h03; wmask[8'h10] = 8'h03;
        mem[8'h11] = 8'h12; wmask[8'h11] = 8'h3f;
        mem[8'h12] = 8'h04; wmask[8'h12] = 8'h1f;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        return (a == 8'h0c) ? {7'h0, trap} : mem[a];
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        mem[a] = (mem[a] & ~wmask[a]) | (d & wmask[a]);
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0]  m08, m10;
        logic [25:0] trim;
        m08  = mem[8'h08];
        m10  = mem[8'h10];
        trim = {m10[1:0], mem[8'h0f], mem[8'h0e], mem[8'h0d]};
        check({tag, ".pll_ctl"}, {29'h0, pll_bypass, pll_dco_ena, pll_ena},
              {29'h0, mem[8'h09][0], m08[1:0]});
        check({tag, ".irq_rst"}, {30'h0, irq, ext_reset}, {30'h0, mem[8'h0a][0], mem[8'h0b][0]});
        check({tag, ".pll_trim"}, {6'h0, pll_trim}, {6'h0, trim});
        check({tag, ".pll_sel_div"}, {21'h0, pll_sel, pll_div},
              {21'h0, mem[8'h11][5:0], mem[8'h12][4:0]});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            hk.hk_sdi = b[i];
            wait_clk(HALF);
            hk.hk_sck = 1'b1;
            wait_clk(HALF);
            hk.hk_sck = 1'b0;
        end
    endtask

    // Full transfer of n data bytes from tx_buf; reads are queued from the model when push_model is set.
    task automatic spi_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n, input bit push_model);
        logic       rd, wr;
        logic [7:0] a;
        rd = (cmd == 8'h40) || (cmd == 8'hC0);
        wr = (cmd == 8'h80) || (cmd == 8'hC0);
        for (int k = 0; k < n; k++) begin
            a = addr + 8'(k);
            if (rd && push_model) exp_q.push_back(model_read(a));
            if (wr) model_write(a, tx_buf[k]);
        end
        hk.hk_csb = 1'b0;
        wait_clk(HALF);
        spi_bits(cmd, 8);
        spi_bits(addr, 8);
        for (int k = 0; k < n; k++) spi_bits(tx_buf[k], 8);
        wait_clk(HALF);
        hk.hk_csb = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic pulse_reset(input int n);
        resetb = 1'b0;
        wait_clk(n);
        resetb = 1'b1;
        model_reset();
        wait_clk(4);
    endtask

    initial begin : monitor
        int unsigned nb;
        logic [7:0]  sh;
        nb = 0;
        sh = '0;
        forever begin
            @(posedge hk.hk_sck or posedge hk.hk_csb);
            if (hk.hk_csb === 1'b1) begin
                nb = 0;
            end else if (hk.hk_sdo_oe === 1'b1) begin
                sh = {sh[6:0], hk.hk_sdo};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sdo_unexpected: got 0x%0h expected no read byte", sh);
                    end else begin
                        check("sdo_byte", {24'h0, sh}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] stream_exp[19];
        logic [7:0] cmd, addr;
        int         n, sel;
        stream_exp = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
                       8'h00, 8'h00, 8'h00, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};
        hk.hk_sck = 1'b0;
        hk.hk_csb = 1'b1;
        hk.hk_sdi = 1'b0;
        trap      = 1'b0;
        for (int i = 0; i < 32; i++) tx_buf[i] = 8'h00;
        pulse_reset(4);

        check("rst_trim", {6'h0, pll_trim}, 32'h3ffefff);
        check("rst_sel_div", {21'h0, pll_sel, pll_div}, {21'h0, 6'h12, 5'h04});
        check("rst_ctl", {27'h0, pll_ena, pll_dco_ena, pll_bypass, irq, ext_reset}, 32'b01100);
        check("rst_sdo", {30'h0, hk.hk_sdo, hk.hk_sdo_oe}, 32'h0);
        check_outputs("rst");

        exp_q.push_back(8'h11);
        spi_txn(8'h40, 8'h03, 1, 1'b0);

        for (int i = 0; i < 19; i++) exp_q.push_back(stream_exp[i]);
        spi_txn(8'h40, 8'h00, 19, 1'b0);

        spi_txn(8'h40, 8'hfe, 4, 1'b1);

        tx_buf[0] = 8'h01;
        spi_txn(8'h80, 8'h0b, 1, 1'b1);
        check("ext_reset_set", {31'h0, ext_reset}, 32'h1);
        tx_buf[0] = 8'h00;
        spi_txn(8'h80, 8'h0b, 1, 1'b1);
        check("ext_reset_clr", {31'h0, ext_reset}, 32'h0);
        exp_q.push_back(8'h00);
        spi_txn(8'h40, 8'h0b, 1, 1'b0);

        tx_buf[0] = 8'hff;
        spi_txn(8'h80, 8'h11, 1, 1'b1);
        check("pll_sel_mask", {26'h0, pll_sel}, 32'h3f);
        exp_q.push_back(8'h3f);
        spi_txn(8'h40, 8'h11, 1, 1'b0);
        tx_buf[0] = 8'h55;
        spi_txn(8'h80, 8'h03, 1, 1'b1);
        exp_q.push_back(8'h11);
        spi_txn(8'h40, 8'h03, 1, 1'b0);

        hk.hk_csb = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h80, 8);
        spi_bits(8'h0d, 8);
        spi_bits(8'h00, 4);
        wait_clk(HALF);
        hk.hk_csb = 1'b1;
        wait_clk(2 * HALF);
        exp_q.push_back(8'hff);
        spi_txn(8'h40, 8'h0d, 1, 1'b0);
        check_outputs("partial");

        trap = 1'b1;
        exp_q.push_back(8'h01);
        spi_txn(8'h40, 8'h0c, 1, 1'b0);
        trap = 1'b0;

        tx_buf[0] = 8'h5a; tx_buf[1] = 8'h00; tx_buf[2] = 8'hc3;
        spi_txn(8'hC0, 8'h0d, 3, 1'b1);
        spi_txn(8'h40, 8'h0d, 3, 1'b1);
        check_outputs("rdwr");

        tx_buf[0] = 8'h01;
        spi_txn(8'h20, 8'h0b, 1, 1'b1);
        check("bad_cmd_no_write", {31'h0, ext_reset}, 32'h0);

        // Chip select held low across reset: the following bytes must be ignored.
        hk.hk_csb = 1'b0;
        wait_clk(2);
        pulse_reset(3);
        spi_bits(8'h80, 8);
        spi_bits(8'h0b, 8);
        spi_bits(8'h01, 8);
        wait_clk(HALF);
        hk.hk_csb = 1'b1;
        wait_clk(2 * HALF);
        check("csb_low_reset_ignored", {31'h0, ext_reset}, 32'h0);

        tx_buf[0] = 8'h00;
        spi_txn(8'h80, 8'h09, 1, 1'b1);
        check("bypass_cleared", {31'h0, pll_bypass}, 32'h0);
        pulse_reset(1);
        check("bypass_after_reset", {31'h0, pll_bypass}, 32'h1);
        exp_q.push_back(8'h01);
        spi_txn(8'h40, 8'h09, 1, 1'b0);

        for (int t = 0; t < 20; t++) begin
            sel = $urandom_range(0, 7);
            if (sel < 3)      cmd = 8'h80;
            else if (sel < 5) cmd = 8'h40;
            else if (sel < 7) cmd = 8'hC0;
            else              cmd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) addr = 8'($urandom_range(0, 255));
            else                           addr = 8'($urandom_range(0, 20));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom_range(0, 255));
            trap = 1'($urandom_range(0, 1));
            spi_txn(cmd, addr, n, 1'b1);
            check_outputs("rand");
        end

        check("queue_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
